// File: rtl/pipe_stage_skid_reg.sv
// Parametrised inter-stage pipeline register with a valid/ready handshake,
// a 2-entry skid buffer (main reg M + skid reg S), flush, and PC-carrying bubbles.
module pipe_stage_skid_reg #(
  parameter int              WIDTH    = 400,
  parameter int              PC_W     = 32,
  parameter int              PC_LSB   = 0,
  parameter bit              KEEP_PC  = 1'b1,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_3000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_msg,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_msg,
  input  logic             i_flush,
  input  logic [PC_W-1:0]  i_flush_pc,
  output logic [1:0]       o_occupancy
);

  generate
    if (PC_LSB + PC_W > WIDTH) begin : g_pc_range_check
      $error("pipe_stage_skid_reg: PC field does not fit inside the payload");
    end
  endgenerate

  // A bubble is all-zero except, when KEEP_PC is set, the PC field.
  function automatic logic [WIDTH-1:0] make_bubble(input logic [PC_W-1:0] pc);
    logic [WIDTH-1:0] b;
    b = '0;
    if (KEEP_PC) b[PC_LSB +: PC_W] = pc;
    return b;
  endfunction

  logic [WIDTH-1:0] r_m;
  logic             r_mv;
  logic [WIDTH-1:0] r_s;
  logic             r_sv;
  logic             r_in_ready;

  logic [WIDTH-1:0] w_m_nxt;
  logic             w_mv_nxt;
  logic [WIDTH-1:0] w_s_nxt;
  logic             w_sv_nxt;
  logic             w_accept;
  logic             w_emit;

  assign w_accept = i_in_valid & r_in_ready;
  assign w_emit   = r_mv & i_out_ready;

  // S always drains into M before new input can reach M, which keeps the order FIFO.
  always_comb begin
    w_m_nxt  = r_m;
    w_mv_nxt = r_mv;
    w_s_nxt  = r_s;
    w_sv_nxt = r_sv;
    if (i_flush) begin
      w_m_nxt  = make_bubble(i_flush_pc);
      w_mv_nxt = 1'b0;
      w_sv_nxt = 1'b0;
    end else if (!r_mv || w_emit) begin
      if (r_sv) begin
        w_m_nxt  = r_s;
        w_mv_nxt = 1'b1;
        w_sv_nxt = w_accept;
        if (w_accept) w_s_nxt = i_in_msg;
      end else begin
        w_mv_nxt = w_accept;
        if (w_accept) w_m_nxt = i_in_msg;
      end
    end else if (w_accept) begin
      w_s_nxt  = i_in_msg;
      w_sv_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m        <= make_bubble(RESET_PC);
      r_mv       <= 1'b0;
      r_s        <= '0;
      r_sv       <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_m        <= w_m_nxt;
      r_mv       <= w_mv_nxt;
      r_s        <= w_s_nxt;
      r_sv       <= w_sv_nxt;
      r_in_ready <= !w_sv_nxt;
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_mv;
  assign o_out_msg   = r_m;
  assign o_occupancy = {1'b0, r_mv} + {1'b0, r_sv};

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed bench for pipe_stage_skid_reg: a vector table for the default 400-bit
// stage plus hand-written sequences for async reset and a KEEP_PC=0 variant.
module tb_pipe_stage_skid_reg;

  typedef struct {
    logic        v;
    logic [31:0] msg;
    logic        ordy;
    logic        flush;
    logic [31:0] fpc;
    logic        eValid;
    logic [31:0] eMsg;
    logic        eReady;
    logic [1:0]  eOcc;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         inValid, inReady, outValid, outReady, flush;
  logic [399:0] inMsg, outMsg;
  logic [31:0]  flushPc;
  logic [1:0]   occ;

  logic         bInValid, bInReady, bOutValid, bOutReady, bFlush;
  logic [63:0]  bInMsg, bOutMsg;
  logic [31:0]  bFlushPc;
  logic [1:0]   bOcc;

  int numCompared   = 0;
  int numMismatched = 0;
  vec_t vecs[$];

  pipe_stage_skid_reg #(.WIDTH(400)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(inValid), .o_in_ready(inReady), .i_in_msg(inMsg),
    .o_out_valid(outValid), .i_out_ready(outReady), .o_out_msg(outMsg),
    .i_flush(flush), .i_flush_pc(flushPc), .o_occupancy(occ)
  );

  pipe_stage_skid_reg #(.WIDTH(64), .PC_LSB(16), .KEEP_PC(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(bInValid), .o_in_ready(bInReady), .i_in_msg(bInMsg),
    .o_out_valid(bOutValid), .i_out_ready(bOutReady), .o_out_msg(bOutMsg),
    .i_flush(bFlush), .i_flush_pc(bFlushPc), .o_occupancy(bOcc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [399:0] act, input logic [399:0] exp);
    numCompared++;
    if (act !== exp) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t makeVec(input logic v, input logic [31:0] msg, input logic ordy,
                                   input logic fl, input logic [31:0] fpc, input logic ev,
                                   input logic [31:0] em, input logic er, input logic [1:0] eo);
    vec_t t;
    t.v = v; t.msg = msg; t.ordy = ordy; t.flush = fl; t.fpc = fpc;
    t.eValid = ev; t.eMsg = em; t.eReady = er; t.eOcc = eo;
    return t;
  endfunction

  // Drive one vector away from the edge, then let one rising edge happen.
  task automatic applyStimulus(input vec_t t);
    @(negedge clk);
    inValid  = t.v;
    inMsg    = {368'd0, t.msg};
    outReady = t.ordy;
    flush    = t.flush;
    flushPc  = t.fpc;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input vec_t t, input string tag);
    checkVal({tag, ".out_valid"}, {399'd0, outValid}, {399'd0, t.eValid});
    checkVal({tag, ".out_msg"},   outMsg,              {368'd0, t.eMsg});
    checkVal({tag, ".in_ready"},  {399'd0, inReady},  {399'd0, t.eReady});
    checkVal({tag, ".occupancy"}, {398'd0, occ},      {398'd0, t.eOcc});
  endtask

  initial begin
    rst_n = 1'b0;
    inValid = 1'b0; inMsg = '0; outReady = 1'b1; flush = 1'b0; flushPc = '0;
    bInValid = 1'b0; bInMsg = '0; bOutReady = 1'b1; bFlush = 1'b0; bFlushPc = '0;

    // Vector table: inputs for one edge, then the state expected after it.
    for (int k = 1; k <= 8; k++)
      vecs.push_back(makeVec(1, k, 1, 0, 0, 1, k, 1, 1));
    vecs.push_back(makeVec(0, 0,    1, 0, 0, 0, 8,    1, 0));
    vecs.push_back(makeVec(1, 'hA, 0, 0, 0, 1, 'hA, 1, 1));
    vecs.push_back(makeVec(1, 'hB, 0, 0, 0, 1, 'hA, 0, 2));
    vecs.push_back(makeVec(1, 'hC, 0, 0, 0, 1, 'hA, 0, 2));
    vecs.push_back(makeVec(1, 'hC, 1, 0, 0, 1, 'hB, 1, 1));
    vecs.push_back(makeVec(1, 'hC, 1, 0, 0, 1, 'hC, 1, 1));
    vecs.push_back(makeVec(0, 0,    1, 0, 0, 0, 'hC, 1, 0));
    vecs.push_back(makeVec(1, 'hD, 0, 0, 0, 1, 'hD, 1, 1));
    vecs.push_back(makeVec(1, 'hE, 0, 0, 0, 1, 'hD, 0, 2));
    vecs.push_back(makeVec(1, 'hF, 0, 1, 32'hfac1_3215, 0, 32'hfac1_3215, 1, 0));
    vecs.push_back(makeVec(0, 0,    1, 0, 0, 0, 32'hfac1_3215, 1, 0));
    vecs.push_back(makeVec(1, 'h11, 1, 1, 32'h1234, 0, 32'h1234, 1, 0));
    vecs.push_back(makeVec(0, 0,    1, 0, 0, 0, 32'h1234, 1, 0));
    vecs.push_back(makeVec(1, 'h21, 0, 0, 0, 1, 'h21, 1, 1));
    vecs.push_back(makeVec(1, 'h22, 0, 0, 0, 1, 'h21, 0, 2));
    vecs.push_back(makeVec(0, 0,    1, 0, 0, 1, 'h22, 1, 1));
    vecs.push_back(makeVec(1, 'h23, 1, 0, 0, 1, 'h23, 1, 1));
    vecs.push_back(makeVec(0, 0,    1, 0, 0, 0, 'h23, 1, 0));

    repeat (3) @(posedge clk);
    #1;
    checkVal("reset.out_valid", {399'd0, outValid}, 400'd0);
    checkVal("reset.in_ready",  {399'd0, inReady},  400'd1);
    checkVal("reset.occupancy", {398'd0, occ},      400'd0);
    checkVal("reset.out_msg",   outMsg,             400'h3000);
    checkVal("reset.b_out_msg", {336'd0, bOutMsg},  400'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], $sformatf("vec%0d", i));
    end

    // Async reset dropped between edges while both entries are held.
    applyStimulus(makeVec(1, 'h31, 0, 0, 0, 1, 'h31, 1, 1));
    applyStimulus(makeVec(1, 'h32, 0, 0, 0, 1, 'h31, 0, 2));
    checkVal("stall.occupancy", {398'd0, occ}, 400'd2);
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("areset.out_valid", {399'd0, outValid}, 400'd0);
    checkVal("areset.occupancy", {398'd0, occ},      400'd0);
    checkVal("areset.in_ready",  {399'd0, inReady},  400'd1);
    checkVal("areset.out_msg",   outMsg,             400'h3000);
    @(negedge clk);
    rst_n = 1'b1;
    inValid = 1'b0;
    applyStimulus(makeVec(1, 'h41, 1, 0, 0, 1, 'h41, 1, 1));
    checkOutput(makeVec(1, 'h41, 1, 0, 0, 1, 'h41, 1, 1), "resume0");
    applyStimulus(makeVec(1, 'h42, 1, 0, 0, 1, 'h42, 1, 1));
    checkOutput(makeVec(1, 'h42, 1, 0, 0, 1, 'h42, 1, 1), "resume1");
    applyStimulus(makeVec(0, 0, 1, 0, 0, 0, 'h42, 1, 0));

    // KEEP_PC=0 variant: PC bits pass through untouched, flush yields all-zero.
    @(negedge clk);
    bInValid = 1'b1; bInMsg = 64'hAAAA_1234_5678_BBBB; bOutReady = 1'b1;
    @(posedge clk);
    #1;
    checkVal("b.stream.out_msg",   {336'd0, bOutMsg},   {336'd0, 64'hAAAA_1234_5678_BBBB});
    checkVal("b.stream.out_valid", {399'd0, bOutValid}, 400'd1);
    @(negedge clk);
    bInMsg = 64'h0123_4567_89AB_CDEF; bFlush = 1'b1; bFlushPc = 32'hdead_beef;
    @(posedge clk);
    #1;
    checkVal("b.flush.out_msg",   {336'd0, bOutMsg},   400'd0);
    checkVal("b.flush.out_valid", {399'd0, bOutValid}, 400'd0);
    checkVal("b.flush.occupancy", {398'd0, bOcc},      400'd0);
    checkVal("b.flush.in_ready",  {399'd0, bInReady},  400'd1);
    @(negedge clk);
    bFlush = 1'b0; bInValid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
